// File: rtl/alsu_cmd_seq.sv
`default_nettype none
// =====================================================================
// Module : alsu_cmd_seq
// Brief  : Command FIFO and issue sequencer driving the ALSU input pins,
//          with result strobes delayed to line up with the ALSU output.
//          Define ALSU_CMD_SEQ_REPEAT_EN to honour cmd_repeat.
// Rev    : 1.0  initial release
// =====================================================================
module alsu_cmd_seq #(
  parameter int DEPTH    = 4,
  parameter int ALSU_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [2:0]       cmd_A,
  input  logic signed [2:0]       cmd_B,
  input  logic        [2:0]       cmd_opcode,
  input  logic                    cmd_cin,
  input  logic                    cmd_serial_in,
  input  logic                    cmd_direction,
  input  logic                    cmd_red_op_A,
  input  logic                    cmd_red_op_B,
  input  logic                    cmd_bypass_A,
  input  logic                    cmd_bypass_B,
  input  logic        [2:0]       cmd_repeat,
  output logic signed [2:0]       A,
  output logic signed [2:0]       B,
  output logic        [2:0]       opcode,
  output logic                    cin,
  output logic                    serial_in,
  output logic                    direction,
  output logic                    red_op_A,
  output logic                    red_op_B,
  output logic                    bypass_A,
  output logic                    bypass_B,
  output logic                    issue_valid,
  output logic                    res_valid,
  output logic                    res_last,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 16;
`ifdef ALSU_CMD_SEQ_REPEAT_EN
  localparam int EW = DW + 3;
`else
  localparam int EW = DW;
`endif
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [EW-1:0]       r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr, w_rd_sel;
  logic [CW-1:0]       r_count;
  logic [0:0]          r_state, w_state_nxt;
  logic [DW-1:0]       r_drive;
  logic [EW-1:0]       w_push_data, w_head;
  logic [ALSU_LAT-1:0] r_vpipe, r_lpipe;
  logic                w_push, w_pop, w_last, w_load, w_load_idle, w_more, w_rep_zero;

`ifdef ALSU_CMD_SEQ_REPEAT_EN
  assign w_push_data = {cmd_repeat, cmd_A, cmd_B, cmd_opcode, cmd_cin, cmd_serial_in,
                        cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A, cmd_bypass_B};
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^cmd_repeat;
  assign w_push_data = {cmd_A, cmd_B, cmd_opcode, cmd_cin, cmd_serial_in,
                        cmd_direction, cmd_red_op_A, cmd_red_op_B, cmd_bypass_A, cmd_bypass_B};
`endif

  assign cmd_ready = (r_count != CW'(DEPTH));
  assign count     = r_count;
  assign w_push    = cmd_valid && cmd_ready;
  // The entry being issued stays in the FIFO until its last repetition.
  assign w_more    = (r_count > CW'(1));
  assign w_rd_sel  = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
  assign w_head    = r_mem[w_rd_sel];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

`ifdef ALSU_CMD_SEQ_REPEAT_EN
  logic [2:0] r_rep_cnt;
  assign w_rep_zero = (r_rep_cnt == 3'd0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 r_rep_cnt <= 3'd0;
    else if (w_load)                          r_rep_cnt <= w_head[EW-1 -: 3];
    else if (r_state == S_ISSUE && !w_rep_zero) r_rep_cnt <= r_rep_cnt - 3'd1;
  end
`else
  assign w_rep_zero = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0)          w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_rep_zero && !w_more)  w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue_valid = (r_state == S_ISSUE);
    w_last      = issue_valid && w_rep_zero;
    w_pop       = w_last;
    w_load      = ((r_state == S_IDLE) && (r_count != '0)) || (w_last && w_more);
    w_load_idle = w_last && !w_more;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_drive <= '0;
    else if (w_load)      r_drive <= w_head[DW-1:0];
    else if (w_load_idle) r_drive <= '0;
  end

  assign A         = r_drive[15:13];
  assign B         = r_drive[12:10];
  assign opcode    = r_drive[9:7];
  assign cin       = r_drive[6];
  assign serial_in = r_drive[5];
  assign direction = r_drive[4];
  assign red_op_A  = r_drive[3];
  assign red_op_B  = r_drive[2];
  assign bypass_A  = r_drive[1];
  assign bypass_B  = r_drive[0];

  generate
    if (ALSU_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vpipe <= '0;
          r_lpipe <= '0;
        end else begin
          r_vpipe <= issue_valid;
          r_lpipe <= w_last;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vpipe <= '0;
          r_lpipe <= '0;
        end else begin
          r_vpipe <= {r_vpipe[ALSU_LAT-2:0], issue_valid};
          r_lpipe <= {r_lpipe[ALSU_LAT-2:0], w_last};
        end
      end
    end
  endgenerate

  assign res_valid = r_vpipe[ALSU_LAT-1];
  assign res_last  = r_lpipe[ALSU_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_alsu_cmd_seq.sv
`default_nettype none
// Testbench for alsu_cmd_seq: queue-based reference model checked every
// cycle, plus directed literal checks of latency, repeat and reset.
module tb_alsu_cmd_seq;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 20 + CW;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic [6:0] ctrl;   // cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B
    logic [2:0] rep;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  cmd_t din = '0;

  logic cmd_ready, issue_valid, res_valid, res_last;
  logic signed [2:0] A, B;
  logic [2:0] opcode;
  logic cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alsu_cmd_seq #(.DEPTH(DEPTH), .ALSU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(din.a), .cmd_B(din.b), .cmd_opcode(din.op),
    .cmd_cin(din.ctrl[6]), .cmd_serial_in(din.ctrl[5]), .cmd_direction(din.ctrl[4]),
    .cmd_red_op_A(din.ctrl[3]), .cmd_red_op_B(din.ctrl[2]),
    .cmd_bypass_A(din.ctrl[1]), .cmd_bypass_B(din.ctrl[0]), .cmd_repeat(din.rep),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
    .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .issue_valid(issue_valid),
    .res_valid(res_valid), .res_last(res_last), .count(count)
  );

  // ---------------- reference model ----------------
  cmd_t           mq[$];      // front entry is the one currently being issued
  cmd_t           m_cur = '0;
  bit             m_iv = 1'b0;
  int             m_rem = 0;
  bit [LAT-1:0]   hv = '0, hl = '0;
  bit             m_push;

  function automatic int rep_of(cmd_t c);
`ifdef ALSU_CMD_SEQ_REPEAT_EN
    return int'(c.rep);
`else
    return 0 * int'(c.rep);
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_cur = '0; m_iv = 1'b0; m_rem = 0; hv = '0; hl = '0;
    end else begin
      m_push = cmd_valid && (mq.size() != DEPTH);
      hv = {hv[LAT-2:0], m_iv};
      hl = {hl[LAT-2:0], m_iv && (m_rem == 0)};
      if (!m_iv) begin
        if (mq.size() > 0) begin
          m_iv = 1'b1; m_cur = mq[0]; m_rem = rep_of(mq[0]);
        end
      end else if (m_rem > 0) begin
        m_rem--;
      end else begin
        void'(mq.pop_front());
        if (mq.size() > 0) begin
          m_cur = mq[0]; m_rem = rep_of(mq[0]);
        end else begin
          m_iv = 1'b0; m_cur = '0;
        end
      end
      if (m_push) mq.push_back(din);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [VW-1:0] got_v, exp_v;
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk); #1;
      got_v = {A, B, opcode, cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B,
               issue_valid, res_valid, res_last, count, cmd_ready};
      exp_v = {(m_iv ? {m_cur.a, m_cur.b, m_cur.op, m_cur.ctrl} : 16'h0),
               m_iv, hv[LAT-1], hl[LAT-1], CW'(mq.size()), (mq.size() != DEPTH)};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got_v, exp_v);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #2;
  endtask

  function automatic cmd_t mk(input int a, input int b, input int op, input int ctrl, input int rep);
    cmd_t c;
    c.a = 3'(a); c.b = 3'(b); c.op = 3'(op); c.ctrl = 7'(ctrl); c.rep = 3'(rep);
    return c;
  endfunction

  // Presents c until accepted; returns just after the accepting edge.
  task automatic send(input cmd_t c);
    bit acc;
    int guard = 0;
    din = c; cmd_valid = 1'b1;
    forever begin
      acc = cmd_ready;
      step();
      if (acc) break;
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic burst(input string nm, input cmd_t c, input int exp_issues);
    int n_iv = 0, n_rv = 0, n_rl = 0;
    send(c);
    repeat (14) begin
      step();
      n_iv += int'(issue_valid); n_rv += int'(res_valid); n_rl += int'(res_last);
    end
    chk({nm, "_issues"}, n_iv, exp_issues);
    chk({nm, "_resvalid"}, n_rv, exp_issues);
    chk({nm, "_reslast"}, n_rl, 1);
  endtask

  int n_stale;

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_issue", int'(issue_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_resv", int'(res_valid), 0);
    rst = 1'b1;
    step();

    // single command, latency A=3 B=1 opcode=2
    send(mk(3, 1, 2, 0, 0));
    chk("t1_count_k", int'(count), 1);
    chk("t1_issue_k", int'(issue_valid), 0);
    step();
    chk("t1_issue_k1", int'(issue_valid), 1);
    chk("t1_A", int'($unsigned(A)), 3);
    chk("t1_B", int'($unsigned(B)), 1);
    chk("t1_opcode", int'(opcode), 2);
    step();
    chk("t1_issue_k2", int'(issue_valid), 0);
    chk("t1_resv_k2", int'(res_valid), 0);
    step();
    chk("t1_resv_k3", int'(res_valid), 1);
    chk("t1_resl_k3", int'(res_last), 1);
    step();
    chk("t1_resv_k4", int'(res_valid), 0);
    repeat (3) step();

    // fill behind a long repeat head, 5th push must wait
    send(mk(0, 0, 4, 7'b0110000, 7));
    send(mk(1, 2, 0, 7'b1000000, 0));
    send(mk(2, 3, 1, 7'b0000010, 0));
    send(mk(3, 4, 3, 7'b0001000, 0));
`ifdef ALSU_CMD_SEQ_REPEAT_EN
    chk("t2_count_full", int'(count), DEPTH);
    chk("t2_ready_full", int'(cmd_ready), 0);
`endif
    send(mk(5, 6, 5, 7'b0000001, 0));
    repeat (20) step();

    // shift sequence: opcode 4, direction 1, serial_in 1, repeat 5
`ifdef ALSU_CMD_SEQ_REPEAT_EN
    burst("t3_shift", mk(0, 0, 4, 7'b0110000, 5), 6);
`else
    burst("t3_shift", mk(0, 0, 4, 7'b0110000, 5), 1);
`endif

    // wrap-around with 2*DEPTH+1 commands, including opcodes 6 and 7
    for (int i = 0; i < 2 * DEPTH + 1; i++)
      send(mk(i, 7 - i, i % 8, i * 13, i % 3));
    repeat (60) step();
    chk("t4_count", int'(count), 0);
    chk("t4_issue", int'(issue_valid), 0);
    chk("t4_opcode", int'(opcode), 0);
    chk("t4_A", int'($unsigned(A)), 0);

    // reset while busy
    send(mk(1, 2, 4, 7'b0110000, 6));
    send(mk(2, 1, 5, 7'b0010000, 2));
    send(mk(3, 3, 0, 7'b0000000, 1));
    step(); step();
    rst = 1'b0;
    #1;
    chk("t5_ready", int'(cmd_ready), 1);
    chk("t5_issue", int'(issue_valid), 0);
    chk("t5_resv", int'(res_valid), 0);
    chk("t5_count", int'(count), 0);
    chk("t5_opcode", int'(opcode), 0);
    step(); step();
    rst = 1'b1;
    n_stale = 0;
    repeat (5) begin
      step();
      n_stale += int'(res_valid) + int'(issue_valid);
    end
    chk("t5_stale", n_stale, 0);
    send(mk(2, 2, 0, 0, 0));
    step();
    chk("t5_reissue", int'(issue_valid), 1);
    chk("t5_reissue_A", int'($unsigned(A)), 2);
    repeat (4) step();

    // cmd_repeat=3
`ifdef ALSU_CMD_SEQ_REPEAT_EN
    burst("t6_rep3", mk(1, 1, 1, 0, 3), 4);
`else
    burst("t6_rep3", mk(1, 1, 1, 0, 3), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alsu_cmd_seq.md
# alsu_cmd_seq

Command sequencer that sits directly upstream of the ALSU. It accepts ALSU commands over a valid/ready handshake and buffers them in a small FIFO. It issues one command per cycle onto the ALSU input pins, optionally repeating a command for multi-step shift/rotate sequences. It also produces a result-valid strobe aligned with the ALSU's registered output, so downstream logic knows which `out` samples are meaningful.

## Interface
- `DEPTH`, 4, FIFO depth in commands; power of 2, minimum 2.
- `ALSU_LAT`, 2, ALSU input-to-output latency in cycles; used to delay `res_valid`/`res_last`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_A`, `cmd_B`  in  3 each  signed operands.
- `cmd_opcode`  in  3  ALSU opcode.
- `cmd_cin`, `cmd_serial_in`, `cmd_direction`, `cmd_red_op_A`, `cmd_red_op_B`, `cmd_bypass_A`, `cmd_bypass_B`  in  1 each  ALSU control bits.
- `cmd_repeat`  in  3  extra issue count; command is issued `cmd_repeat+1` times.
- `A`, `B`, `opcode`, `cin`, `serial_in`, `direction`, `red_op_A`, `red_op_B`, `bypass_A`, `bypass_B`  out  ALSU widths  registered drive to the ALSU inputs.
- `issue_valid`  out  1  current ALSU input pattern is a real command.
- `res_valid`  out  1  `issue_valid` delayed `ALSU_LAT` cycles.
- `res_last`  out  1  marks the last repetition, delayed `ALSU_LAT` cycles.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Push:** a command is pushed on a rising edge where `cmd_valid && cmd_ready`.
- **Ready:** `cmd_ready = (count != DEPTH)`, combinational from `count` only.
  - There is no ready-through-pop: when full, a push is refused even if a pop happens in the same cycle.
- **FIFO structure:** circular buffer with wrap-around read/write pointers. A push and a pop in the same cycle leave `count` unchanged.
- **State machine:**
  - **IDLE:** outputs hold the idle pattern, all-zero (opcode 0, A=B=0, all control bits 0), so ALSU `out` settles to 0. `issue_valid=0`.
    - If `count != 0`: load the head entry into the output registers, set `rep_cnt = cmd_repeat`, raise `issue_valid`, go to ISSUE.
  - **ISSUE, `rep_cnt != 0`:** hold the outputs, decrement `rep_cnt`, keep `issue_valid=1`.
  - **ISSUE, `rep_cnt == 0`:** pop the head entry and drive `last=1` for this cycle.
    - If another entry is available (count after pop > 0), load it on the same edge (back-to-back, no bubble) and stay in ISSUE.
    - Otherwise load the idle pattern and return to IDLE.
- **Result strobes:** `res_valid`/`res_last` come from an `ALSU_LAT`-stage shift register fed by `issue_valid`/`last`.
- **No filtering:** invalid opcodes (6, 7) and invalid red_op combinations are issued unchanged; they are the ALSU's responsibility.

## Timing
- **Reset values:** while `rst=0`, all outputs are 0 except `cmd_ready`, which is 1. This covers the FIFO pointers, `count`, `rep_cnt`, state (IDLE) and the delay pipeline.
- **Reset mid-operation:** the FIFO contents are discarded, and in-flight `res_valid` bits are cleared immediately.
- **Latency, push into an empty IDLE block at edge k:**
  - ALSU inputs change and `issue_valid` rises after edge k+1.
  - The ALSU output is valid after edge k+1+`ALSU_LAT`, coincident with `res_valid=1`.
- **Repeat:** a command with `cmd_repeat=r` holds `issue_valid` for r+1 consecutive cycles. `res_last` is high only on the final cycle.
- **Throughput:** one issue per cycle sustained while the FIFO is non-empty.
- **Occupancy:** `count` reaches `DEPTH` exactly when full. `cmd_ready` falls in the same cycle that `count` reaches `DEPTH`.

## Configuration
- `ALSU_CMD_SEQ_REPEAT_EN`:
  - **Defined:** `cmd_repeat` is honoured as above.
  - **Undefined:** `cmd_repeat` is ignored and not stored, `rep_cnt` is removed, and every command issues exactly once with `res_last=1` on every issue.

## Test plan
- Reset, then push a single command {A=3, B=1, opcode=2} at edge k -> `issue_valid` is 1 for exactly one cycle after k+1; `res_valid`=`res_last`=1 one cycle after k+3; ALSU `out`=4.
- Push 5 commands back-to-back with DEPTH=4 and the sequencer stalled behind a `cmd_repeat=7` head command -> `cmd_ready`=0 at `count`=4; the 5th push is held until the first pop; all 5 issue in order with no bubbles.
- Push {opcode=4, direction=1, serial_in=1, `cmd_repeat`=5} -> 6 consecutive issues; ALSU `out` shifts to 6'b111111; `res_last` is high only on the 6th `res_valid`.
- Push 2·DEPTH+1 commands through to check wrap-around -> issue order is identical to push order; `count` returns to 0; outputs return to the all-zero idle pattern.
- Assert `rst`=0 while 3 commands are queued and one is mid-repeat -> all outputs go to 0 and `cmd_ready`=1 immediately; after release, no stale `res_valid` appears and the next push issues normally.
- Build without `ALSU_CMD_SEQ_REPEAT_EN` and push `cmd_repeat`=3 -> single issue with `res_last`=1.
